// File: rtl/and3_arb_pkg.sv
// rtl/and3_arb_pkg.sv - shared types and constants for the and3 round-robin arbiter
package and3_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam int OP_W  = 3;
   localparam int CNT_W = 16;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/and3_arbiter_if.sv
// rtl/and3_arbiter_if.sv - requester/arbiter bundle; ones_cnt exists only with AND3_ARB_STATS_EN
interface and3_arbiter_if
   import and3_arb_pkg::*;
#(
   parameter int N_REQ = 3
);
   localparam int ID_W = id_width(N_REQ);

   logic [N_REQ-1:0]      req;
   logic [OP_W*N_REQ-1:0] ops;
   logic [N_REQ-1:0]      gnt;
   logic                  busy;
   logic                  done;
   logic                  result;
   logic [ID_W-1:0]       result_id;
`ifdef AND3_ARB_STATS_EN
   logic [CNT_W-1:0]      ones_cnt;
`endif

`ifdef AND3_ARB_STATS_EN
   modport master (output req, ops, input gnt, busy, done, result, result_id, ones_cnt);
   modport slave  (input req, ops, output gnt, busy, done, result, result_id, ones_cnt);
`else
   modport master (output req, ops, input gnt, busy, done, result, result_id);
   modport slave  (input req, ops, output gnt, busy, done, result, result_id);
`endif

endinterface

// File: rtl/and3_rr_pick.sv
// rtl/and3_rr_pick.sv - rotating-priority search for the first active request starting at ptr
module and3_rr_pick #(
   parameter int N_REQ = 3,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [ID_W-1:0]  idx
);
   int j;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = ID_W'(j);
         end
      end
   end
endmodule

// File: rtl/and_gate3.sv
// rtl/and_gate3.sv - existing 3-input AND combinational cell
module and_gate3 (
   input  logic e1,
   input  logic e2,
   input  logic e3,
   output logic y
);
   assign y = e1 & e2 & e3;
endmodule

// File: rtl/and3_arbiter.sv
// rtl/and3_arbiter.sv - round-robin sequencer sharing one and_gate3 among N_REQ requesters; optional AND3_ARB_STATS_EN
module and3_arbiter
   import and3_arb_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input logic           clk,
   input logic           rst_n,
   and3_arbiter_if.slave bus
);
   localparam int ID_W = id_width(N_REQ);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_EVAL = EVAL;
   localparam logic [1:0] ST_RESP = RESP;

   logic [1:0]       state;
   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  cur_id;
   logic [OP_W-1:0]  op_r;
   logic [N_REQ-1:0] gnt_r;
   logic             result_r;
   logic [ID_W-1:0]  id_r;
   logic             found;
   logic [ID_W-1:0]  pick_idx;
   logic             and_y;

   and3_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .found (found),
      .idx   (pick_idx)
   );

   and_gate3 u_and (
      .e1 (op_r[0]),
      .e2 (op_r[1]),
      .e3 (op_r[2]),
      .y  (and_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         cur_id   <= '0;
         op_r     <= '0;
         gnt_r    <= '0;
         result_r <= 1'b0;
         id_r     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  op_r   <= bus.ops[int'(pick_idx)*OP_W +: OP_W];
                  cur_id <= pick_idx;
                  gnt_r  <= N_REQ'(1) << pick_idx;
                  state  <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               // result/id are held in their own registers so they stay stable after done
               result_r <= and_y;
               id_r     <= cur_id;
               state    <= ST_RESP;
            end
            ST_RESP: begin
               gnt_r <= '0;
               ptr   <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               gnt_r <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.done      = (state == ST_RESP);
   assign bus.result    = result_r;
   assign bus.result_id = id_r;

`ifdef AND3_ARB_STATS_EN
   logic [CNT_W-1:0] ones_cnt_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_cnt_r <= '0;
      end else if (state == ST_RESP && result_r && ones_cnt_r != '1) begin
         ones_cnt_r <= ones_cnt_r + 1'b1;
      end
   end

   assign bus.ones_cnt = ones_cnt_r;
`endif

endmodule

// File: tb/tb_and3_arbiter.sv
// tb/tb_and3_arbiter.sv - directed and random checks of and3_arbiter against a transaction-level model
module tb_and3_arbiter;
   import and3_arb_pkg::*;

   localparam int N   = 3;
   localparam int IDW = id_width(N);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   and3_arbiter_if #(.N_REQ(N)) bus ();

   and3_arbiter #(.N_REQ(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   free_at = 0;
   int   mptr = 0;
   int   g_cyc = 0;
   bit   g_valid = 0;
   int   exp_id = 0;
   logic exp_res = 1'b0;
   int   dut_ids[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic apply(input logic [N-1:0] r, input logic [3*N-1:0] o);
      bus.req = r;
      bus.ops = o;
   endtask

   task automatic model_reset();
      mptr    = 0;
      g_valid = 0;
      free_at = cyc;
   endtask

   // One clock: decide the grant from the inputs about to be sampled, then check the next cycle
   task automatic tick();
      int  w;
      bit  in_srv;
      bit  exp_done;
      logic [N-1:0] exp_gnt;
      if (cyc >= free_at && bus.req != '0) begin
         w       = model_pick(bus.req, mptr);
         exp_id  = w;
         exp_res = &bus.ops[3*w +: 3];
         g_cyc   = cyc;
         g_valid = 1;
         free_at = cyc + 3;
         mptr    = (w + 1) % N;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      in_srv   = g_valid && (cyc >= g_cyc + 1) && (cyc <= g_cyc + 2);
      exp_done = g_valid && (cyc == g_cyc + 2);
      exp_gnt  = in_srv ? N'(1) << exp_id : '0;
      check("gnt", 32'(bus.gnt), 32'(exp_gnt));
      check("busy", 32'(bus.busy), 32'(in_srv));
      check("done", 32'(bus.done), 32'(exp_done));
      if (exp_done) begin
         check("result", 32'(bus.result), 32'(exp_res));
         check("result_id", 32'(bus.result_id), 32'(exp_id));
      end
      if (bus.done) dut_ids.push_back(int'(bus.result_id));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.req = '0;
      bus.ops = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(bus.gnt), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_result", 32'(bus.result), 0);
      check("rst_result_id", 32'(bus.result_id), 0);
      rst_n = 1'b1;
      model_reset();

      // single request, all ones
      apply(3'b001, 9'b000_000_111);
      tick();
      apply(3'b000, 9'b000_000_000);
      tick();
      check("single_done", 32'(bus.done), 1);
      check("single_result", 32'(bus.result), 1);
      tick();

      // requester 2 alone with partial operands
      apply(3'b100, 9'b101_000_000);
      tick();
      apply(3'b000, 9'b000_000_000);
      tick();
      check("partial_result", 32'(bus.result), 0);
      check("partial_id", 32'(bus.result_id), 2);
      tick();

      // contention held from reset
      apply(3'b111, 9'($urandom));
      do_reset();
      dut_ids.delete();
      repeat (12) tick();
      check("cont_count", 32'(dut_ids.size()), 4);
      if (dut_ids.size() == 4) begin
         check("cont_order0", 32'(dut_ids[0]), 0);
         check("cont_order1", 32'(dut_ids[1]), 1);
         check("cont_order2", 32'(dut_ids[2]), 2);
         check("cont_order3", 32'(dut_ids[3]), 0);
      end
      apply(3'b000, 9'b0);
      tick();

      // late drop: requester 1 releases during EVAL
      dut_ids.delete();
      apply(3'b010, 9'b000_111_000);
      tick();
      apply(3'b000, 9'b000_000_000);
      repeat (5) tick();
      check("drop_count", 32'(dut_ids.size()), 1);
      if (dut_ids.size() == 1) check("drop_id", 32'(dut_ids[0]), 1);

      // reset in the middle of a transaction
      apply(3'b111, 9'b111_111_111);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_gnt", 32'(bus.gnt), 0);
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_done", 32'(bus.done), 0);
      check("midrst_result_id", 32'(bus.result_id), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      dut_ids.delete();
      repeat (3) tick();
      check("midrst_first", (dut_ids.size() > 0) ? 32'(dut_ids[0]) : 32'hFFFF_FFFF, 0);

      // random requests and operands
      for (int i = 0; i < 400; i++) begin
         apply(N'($urandom_range(0, (1 << N) - 1)), 9'($urandom));
         tick();
      end
      apply(3'b000, 9'b0);
      repeat (3) tick();

`ifdef AND3_ARB_STATS_EN
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(3'b001, (i < 5) ? 9'b000_000_111 : 9'b000_000_011);
         tick();
         apply(3'b000, 9'b0);
         tick();
         tick();
      end
      check("ones_cnt", 32'(bus.ones_cnt), 5);
      force dut.ones_cnt_r = 16'hFFFF;
      #1;
      release dut.ones_cnt_r;
      apply(3'b001, 9'b000_000_111);
      tick();
      apply(3'b000, 9'b0);
      tick();
      tick();
      check("ones_cnt_sat", 32'(bus.ones_cnt), 32'h0000_FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
